imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch unit for a mixed 16/32-bit instruction set.
// It reads 64-bit memory lines addressed by pc[7:3], takes halfwords out of the
// line in the memory's lane order and assembles compressed (16-bit) or full
// (32-bit) instructions. A 32-bit instruction that straddles two lines is
// assembled over two cycles through a one-halfword buffer. The instruction
// output is a valid/ready register stage.

module imem_fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [4:0]  im_sel,
    input  logic [63:0] im_line,
    input  logic        redirect_valid,
    input  logic [7:0]  redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [7:0]  instr_pc,
    output logic        instr_is_c
);

    // FETCH: pc points at the start of an instruction.
    // SPLIT: the low half of a line-crossing 32-bit instruction is in buffer
    //        and pc points at its high half in the next line.
    typedef enum logic {
        FETCH = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  pc;
    logic [15:0] buffer;

    logic [1:0]  idx_next;
    logic [15:0] hw_cur;
    logic [15:0] hw_next;
    logic        cur_is_c;
    logic        crossing;
    logic        advance;

    // Bit 0 of a redirect target is forced to zero, so it is never consumed.
    logic        redirect_lsb_unused;
    assign redirect_lsb_unused = redirect_pc[0];

    // The memory line is looked up directly from the byte pc.
    assign im_sel = pc[7:3];

    // Halfword lane order inside a line: lane 0 and 1 live in the upper word,
    // lanes 2 and 3 in the lower word.
    function automatic logic [15:0] pick_hw(input logic [63:0] line,
                                            input logic [1:0]  idx);
        logic [15:0] hw;
        case (idx)
            2'd0:    hw = line[47:32];
            2'd1:    hw = line[63:48];
            2'd2:    hw = line[15:0];
            default: hw = line[31:16];
        endcase
        return hw;
    endfunction

    // Decode the halfwords at pc and derive the advance and crossing conditions.
    // NOTE: every signal driven here is assigned on every path through the
    // block, so no storage (latch) is implied for any of them.
    always_comb begin
        idx_next = pc[2:1] + 2'd1;
        hw_cur   = pick_hw(im_line, pc[2:1]);
        hw_next  = pick_hw(im_line, idx_next);
        cur_is_c = (hw_cur[1:0] != 2'b11);
        crossing = (pc[2:1] == 2'b11);
        advance  = (!instr_valid || instr_ready) && run && !redirect_valid;
    end

    // Fetch state machine, pc, split buffer and the registered instruction stage.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the split buffer is a plain register and is cleared along
            // with the rest of the state so a reset never leaks a stale half.
            state       <= FETCH;
            pc          <= 8'h00;
            buffer      <= 16'h0000;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 8'h00;
            instr_is_c  <= 1'b0;
        end else if (redirect_valid) begin
            // A redirect flushes everything in flight, including a pending split.
            state       <= FETCH;
            pc          <= {redirect_pc[7:1], 1'b0};
            buffer      <= 16'h0000;
            instr_valid <= 1'b0;
        end else if (advance) begin
            case (state)
                FETCH: begin
                    if (cur_is_c) begin
                        instr       <= {16'h0000, hw_cur};
                        instr_pc    <= pc;
                        instr_is_c  <= 1'b1;
                        instr_valid <= 1'b1;
                        pc          <= pc + 8'd2;
                    end else if (!crossing) begin
                        instr       <= {hw_next, hw_cur};
                        instr_pc    <= pc;
                        instr_is_c  <= 1'b0;
                        instr_valid <= 1'b1;
                        pc          <= pc + 8'd4;
                    end else begin
                        // High half lives in the next line: park the low half
                        // and spend one bubble cycle fetching the next line.
                        buffer      <= hw_cur;
                        instr_valid <= 1'b0;
                        pc          <= pc + 8'd2;
                        state       <= SPLIT;
                    end
                end
                SPLIT: begin
                    // pc wrapped past 8'hFE reads line 0 naturally.
                    instr       <= {hw_cur, buffer};
                    instr_pc    <= pc - 8'd2;
                    instr_is_c  <= 1'b0;
                    instr_valid <= 1'b1;
                    pc          <= pc + 8'd2;
                    state       <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end else if (instr_ready) begin
            // Consumer took the instruction but nothing new was produced.
            instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed bench for imem_fetch_ctrl. A small behavioural
// instruction memory answers im_sel combinationally; each directed step drives
// inputs on the falling edge, lets one rising edge pass and compares outputs
// against hand-computed values.

module tb_imem_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        run;
    logic [4:0]  im_sel;
    logic [63:0] im_line;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_is_c;

    // Line layout: [63:48]=lane1 (pc+2), [47:32]=lane0 (pc+0),
    //              [31:16]=lane3 (pc+6), [15:0]=lane2 (pc+4).
    logic [63:0] mem [0:31];

    int n_checks = 0;
    int n_fail   = 0;

    assign im_line = mem[im_sel];

    imem_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .im_sel         (im_sel),
        .im_line        (im_line),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_is_c     (instr_is_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] data,
                                input logic [7:0] pc, input logic is_c);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_instr"}, instr, data);
        check({tag, "_pc"},    {24'd0, instr_pc}, {24'd0, pc});
        check({tag, "_is_c"},  {31'd0, instr_is_c}, {31'd0, is_c});
    endtask

    task automatic expect_idle(input string tag, input logic [4:0] sel);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_sel"},   {27'd0, im_sel}, {27'd0, sel});
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 64'h0;
        // pc0=4505 (C.LI), pc2=0001, pc4=8082, pc6=0113 (low half, crossing)
        mem[0] = {16'h0001, 16'h4505, 16'h0113, 16'h8082};
        // pc8=0020 (high half of 00200113), pc10=4585
        mem[1] = {16'h4585, 16'h0020, 16'h0000, 16'h0000};
        // pc30=0513, pc32=00a0 -> 00a00513
        mem[6] = {16'h00a0, 16'h0513, 16'h0000, 16'h0000};
        // pcFE=4501 (compressed)
        mem[31] = {16'h0000, 16'h0000, 16'h4501, 16'h0000};

        reset = 1'b1; run = 1'b0; instr_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 8'h00;
        @(negedge clk);
        step(); step();

        // Reset state
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc",    {24'd0, instr_pc}, 32'd0);
        check("rst_is_c",  {31'd0, instr_is_c}, 32'd0);
        check("rst_sel",   {27'd0, im_sel}, 32'd0);

        // Compressed stream from pc 0
        reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
        step(); expect_instr("c_li", 32'h0000_4505, 8'h00, 1'b1);
        check("c_li_sel", {27'd0, im_sel}, 32'd0);
        step(); expect_instr("c_nop", 32'h0000_0001, 8'h02, 1'b1);
        step(); expect_instr("c_ret", 32'h0000_8082, 8'h04, 1'b1);

        // Line-crossing 32-bit at pc 6: one bubble then the joined instruction
        step(); expect_idle("cross_bubble", 5'd1);
        step(); expect_instr("cross", 32'h0020_0113, 8'h06, 1'b0);
        check("cross_sel", {27'd0, im_sel}, 32'd1);

        // Back-pressure: three cycles with ready low hold everything
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_instr("stall", 32'h0020_0113, 8'h06, 1'b0);
            check("stall_sel", {27'd0, im_sel}, 32'd1);
        end
        instr_ready = 1'b1;
        step(); expect_instr("after_stall", 32'h0000_4585, 8'h0A, 1'b1);

        // Ready without advance drains the output register
        run = 1'b0;
        step(); expect_idle("drain", 5'd1);

        // 32-bit aligned instruction at pc 8
        mem[1] = {16'h0031, 16'h8133, 16'h0793, 16'h0505};
        redirect_valid = 1'b1; redirect_pc = 8'h08; run = 1'b1;
        step(); expect_idle("redir8", 5'd1);
        redirect_valid = 1'b0;
        step(); expect_instr("w32", 32'h0031_8133, 8'h08, 1'b0);
        step(); expect_instr("w32_next", 32'h0000_0505, 8'h0C, 1'b1);

        // Enter SPLIT at pc 14, then redirect to 8'h31 (bit 0 dropped)
        step(); expect_idle("split_enter", 5'd2);
        redirect_valid = 1'b1; redirect_pc = 8'h31;
        step(); expect_idle("redir_split", 5'd6);
        redirect_valid = 1'b0;
        step(); expect_instr("redir_tgt", 32'h00a0_0513, 8'h30, 1'b0);

        // Compressed at 8'hFE wraps pc to 0
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step(); expect_idle("redir_fe", 5'd31);
        redirect_valid = 1'b0;
        step(); expect_instr("wrap_c", 32'h0000_4501, 8'hFE, 1'b1);
        check("wrap_sel", {27'd0, im_sel}, 32'd0);
        step(); expect_instr("wrap_next", 32'h0000_4505, 8'h00, 1'b1);

        // Crossing at 8'hFE reads line 0; run low in SPLIT keeps the buffer
        mem[31][31:16] = 16'h0593;
        redirect_valid = 1'b1; redirect_pc = 8'hFE;
        step(); expect_idle("redir_fe2", 5'd31);
        redirect_valid = 1'b0;
        step(); expect_idle("wrap_split", 5'd0);
        run = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(); expect_idle("split_hold", 5'd0);
        end
        run = 1'b1;
        step(); expect_instr("wrap_cross", 32'h4505_0593, 8'hFE, 1'b0);
        check("wrap_cross_sel", {27'd0, im_sel}, 32'd0);

        // Reset mid-SPLIT together with a redirect: reset wins, buffer dropped
        redirect_valid = 1'b1; redirect_pc = 8'h06;
        step(); expect_idle("redir6", 5'd0);
        redirect_valid = 1'b0;
        step(); expect_idle("split6", 5'd1);
        reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h40;
        step();
        check("rst2_valid", {31'd0, instr_valid}, 32'd0);
        check("rst2_instr", instr, 32'd0);
        check("rst2_pc",    {24'd0, instr_pc}, 32'd0);
        check("rst2_is_c",  {31'd0, instr_is_c}, 32'd0);
        check("rst2_sel",   {27'd0, im_sel}, 32'd0);
        reset = 1'b0; redirect_valid = 1'b0;
        step(); expect_instr("post_rst", 32'h0000_4505, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
